// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte-stream input and imem/core-control outputs of program_loader
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_hold;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, start, busy, done, error
  );

  modport slave (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata, cpu_hold, start, busy, done, error
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed UART boot loader: assembles words into imem, releases core on good checksum
module program_loader #(
  parameter int       ADDR_WIDTH     = 8,
  parameter int       MAX_WORDS      = 256,
  parameter bit [7:0] SYNC_BYTE      = 8'hA5,
  parameter int       TIMEOUT_CYCLES = 50000
) (
  input logic               clk,
  input logic               reset,
  program_loader_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERR} state_t;

  localparam int             TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]    MAX_W  = 16'(MAX_WORDS);

  state_t                state;
  logic [15:0]           count;
  logic [15:0]           word_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           lanes;
  logic [7:0]            acc;
  logic [TW-1:0]         timer;
  logic                  imem_we, cpu_hold, start, busy, done, error;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic [15:0]           count_in;

  assign count_in       = {bus.rx_data, count[7:0]};
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wdata = imem_wdata;
  assign bus.cpu_hold   = cpu_hold;
  assign bus.start      = start;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cpu_hold   <= 1'b1;
      start      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      lanes      <= '0;
      acc        <= '0;
      timer      <= '0;
    end else begin
      imem_we <= 1'b0;
      start   <= 1'b0;

      // busy mirrors the in-frame states, so it doubles as the timer enable
      if (!busy || bus.rx_valid || timer == T_LAST) timer <= '0;
      else                                          timer <= timer + 1'b1;

      case (state)
        IDLE, DONE, ERR: begin
          if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state    <= CNT_LO;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            acc      <= '0;
          end
        end
        CNT_LO: begin
          if (bus.rx_valid) begin
            count[7:0] <= bus.rx_data;
            state      <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (bus.rx_valid) begin
            count[15:8] <= bus.rx_data;
            if (count_in == 16'd0 || count_in > MAX_W) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bus.rx_valid) begin
            acc      <= acc ^ bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: lanes[7:0]   <= bus.rx_data;
              2'd1: lanes[15:8]  <= bus.rx_data;
              2'd2: lanes[23:16] <= bus.rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                imem_wdata <= {bus.rx_data, lanes};
                word_idx   <= word_idx + 16'd1;
                if (word_idx + 16'd1 == count) state <= CHECK;
              end
            endcase
          end
        end
        CHECK: begin
          if (bus.rx_valid) begin
            busy <= 1'b0;
            if (bus.rx_data == acc) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              start    <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // a byte landing on the expiry cycle wins, so only idle cycles can time out
      if (busy && !bus.rx_valid && timer == T_LAST) begin
        state <= ERR;
        busy  <= 1'b0;
        error <= 1'b1;
      end
    end
  end
endmodule
